// File: rtl/traffic_sensor_conditioner_if.sv
// Sensor-side bus of the traffic sensor conditioner: two raw loop inputs in,
// debounced traffic-present and stuck-sensor flags out.
interface traffic_sensor_conditioner_if;
  logic raw_a;
  logic raw_b;
  logic TA;
  logic TB;
  logic fault_a;
  logic fault_b;

  // Drives the raw loops, observes the conditioned outputs.
  modport master (output raw_a, raw_b, input TA, TB, fault_a, fault_b);
  // The conditioner itself.
  modport slave  (input raw_a, raw_b, output TA, TB, fault_a, fault_b);
endinterface

// File: rtl/traffic_sensor_conditioner.sv
// Two-lane car-detect loop conditioner: each lane is a 2-flop synchroniser
// followed by a debounce FSM with a registered traffic-present output.
// Optional stuck-sensor detection is enabled with macro SENSOR_STUCK_DETECT_EN;
// without it the FAULT state is unreachable and the fault flags are tied 0.

module traffic_sensor_channel #(
  parameter int DEB_CYCLES   = 4,
  parameter int STUCK_CYCLES = 1024,
  parameter int CNT_W        = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic t_o,
  output logic fault_o
);
  typedef enum logic [2:0] {IDLE, QUAL_ON, ACTIVE, QUAL_OFF, FAULT} state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_C   = CNT_W'(DEB_CYCLES);
`ifdef SENSOR_STUCK_DETECT_EN
  // ACTIVE entry clears cnt, so STUCK_CYCLES ACTIVE cycles end at STUCK_CYCLES-1.
  localparam logic [CNT_W-1:0] STUCK_LAST = CNT_W'(STUCK_CYCLES - 1);
  // FAULT entry clears cnt; the DEB_CYCLES-th consecutive low sample releases it.
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
`endif

  logic             sync1_q, s_q;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             t_q;

  // Two-flop synchroniser for the asynchronous loop input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      s_q     <= sync1_q;
    end
  end

`ifdef SENSOR_STUCK_DETECT_EN
  logic fault_q;

  // Debounce / stuck-detect FSM; T and fault are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      t_q     <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (s_q) begin
          state_q <= QUAL_ON;
          cnt_q   <= CNT_ONE;
        end
        QUAL_ON: if (!s_q) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end else if (cnt_q == DEB_C) begin
          state_q <= ACTIVE;
          cnt_q   <= '0;
          t_q     <= 1'b1;
        end else cnt_q <= cnt_q + CNT_ONE;
        ACTIVE: if (!s_q) begin
          state_q <= QUAL_OFF;
          cnt_q   <= CNT_ONE;
        end else if (cnt_q == STUCK_LAST) begin
          state_q <= FAULT;
          cnt_q   <= '0;
          t_q     <= 1'b0;
          fault_q <= 1'b1;
        end else cnt_q <= cnt_q + CNT_ONE;
        QUAL_OFF: if (s_q) begin
          state_q <= ACTIVE;
          cnt_q   <= '0;
        end else if (cnt_q == DEB_C) begin
          state_q <= IDLE;
          cnt_q   <= '0;
          t_q     <= 1'b0;
        end else cnt_q <= cnt_q + CNT_ONE;
        FAULT: if (s_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DEB_LAST) begin
          state_q <= IDLE;
          cnt_q   <= '0;
          fault_q <= 1'b0;
        end else cnt_q <= cnt_q + CNT_ONE;
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          t_q     <= 1'b0;
          fault_q <= 1'b0;
        end
      endcase
    end
  end

  assign fault_o = fault_q;
`else
  // Debounce FSM; ACTIVE holds for as long as the loop stays occupied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      t_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (s_q) begin
          state_q <= QUAL_ON;
          cnt_q   <= CNT_ONE;
        end
        QUAL_ON: if (!s_q) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end else if (cnt_q == DEB_C) begin
          state_q <= ACTIVE;
          cnt_q   <= '0;
          t_q     <= 1'b1;
        end else cnt_q <= cnt_q + CNT_ONE;
        ACTIVE: if (!s_q) begin
          state_q <= QUAL_OFF;
          cnt_q   <= CNT_ONE;
        end
        QUAL_OFF: if (s_q) begin
          state_q <= ACTIVE;
          cnt_q   <= '0;
        end else if (cnt_q == DEB_C) begin
          state_q <= IDLE;
          cnt_q   <= '0;
          t_q     <= 1'b0;
        end else cnt_q <= cnt_q + CNT_ONE;
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          t_q     <= 1'b0;
        end
      endcase
    end
  end

  assign fault_o = 1'b0;
`endif

  assign t_o = t_q;
endmodule

module traffic_sensor_conditioner #(
  parameter int DEB_CYCLES   = 4,
  parameter int STUCK_CYCLES = 1024,
  parameter int CNT_W        = 11
) (
  input logic                         clk,
  input logic                         rst,
  traffic_sensor_conditioner_if.slave bus
);
  localparam int NUM_LANES = 2;

  // Lane 0 is A, lane 1 is B; the lanes share nothing but clock and reset.
  logic [NUM_LANES-1:0] raw, t, flt;

  assign raw = {bus.raw_b, bus.raw_a};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    traffic_sensor_channel #(
      .DEB_CYCLES  (DEB_CYCLES),
      .STUCK_CYCLES(STUCK_CYCLES),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (raw[g]),
      .t_o    (t[g]),
      .fault_o(flt[g])
    );
  end

  assign bus.TA      = t[0];
  assign bus.TB      = t[1];
  assign bus.fault_a = flt[0];
  assign bus.fault_b = flt[1];
endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Bench for traffic_sensor_conditioner: directed vector table, hand-written
// reset and stuck-sensor sequences, then randomized loops against a run-length
// reference model. Builds with or without SENSOR_STUCK_DETECT_EN.
module tb_traffic_sensor_conditioner;
  localparam int DEB   = 4;
  localparam int STUCK = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  traffic_sensor_conditioner_if bus();

  traffic_sensor_conditioner #(
    .DEB_CYCLES  (DEB),
    .STUCK_CYCLES(STUCK),
    .CNT_W       (11)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the output level flips once the synchronised input has
  // disagreed with it for DEB+1 consecutive samples; a lane that stays
  // occupied for STUCK settled samples is faulted until DEB clear samples.
  bit m_s1[2], m_s[2], m_t[2], m_f[2];
  int m_run[2], m_hi[2];

  function automatic void m_reset();
    for (int i = 0; i < 2; i++) begin
      m_s1[i] = 0; m_s[i] = 0; m_t[i] = 0; m_f[i] = 0; m_run[i] = 0; m_hi[i] = 0;
    end
  endfunction

  function automatic void m_step(input bit ra, input bit rb);
    bit r[2];
    r[0] = ra; r[1] = rb;
    for (int i = 0; i < 2; i++) begin
      bit s;
      s = m_s[i];
      m_s[i]  = m_s1[i];
      m_s1[i] = r[i];
      if (m_f[i]) begin
        if (s) m_run[i] = 0;
        else begin
          m_run[i]++;
          if (m_run[i] == DEB) begin m_f[i] = 0; m_run[i] = 0; end
        end
      end else if (s != m_t[i]) begin
        m_run[i]++;
        m_hi[i] = 0;
        if (m_run[i] == DEB + 1) begin m_t[i] = s; m_run[i] = 0; end
      end else begin
`ifdef SENSOR_STUCK_DETECT_EN
        if (m_t[i] && m_run[i] == 0) begin
          m_hi[i]++;
          if (m_hi[i] == STUCK) begin m_t[i] = 0; m_f[i] = 1; m_hi[i] = 0; end
        end else m_hi[i] = 0;
`endif
        m_run[i] = 0;
      end
    end
  endfunction

  // One clock: model follows the edge, outputs are compared at the falling edge.
  task automatic cyc();
    @(posedge clk);
    if (rst) m_reset();
    else m_step(bus.raw_a, bus.raw_b);
    @(negedge clk);
    chk("model_TA", bus.TA, m_t[0]);
    chk("model_TB", bus.TB, m_t[1]);
    chk("model_fault_a", bus.fault_a, m_f[0]);
    chk("model_fault_b", bus.fault_b, m_f[1]);
  endtask

  typedef struct {
    bit ra, rb;
    int n;
    bit ta, tb, fa, fb;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // Directed vectors: drive raw for n cycles, then expect outputs.
    vecs.push_back('{1, 0, 6, 0, 0, 0, 0});   // 6 edges: TA not yet up
    vecs.push_back('{1, 0, 1, 1, 0, 0, 0});   // TA rises on 6th edge after first high sample
    vecs.push_back('{0, 0, 3, 1, 0, 0, 0});   // 3-cycle gap
    vecs.push_back('{1, 0, 10, 1, 0, 0, 0});  // gap absorbed
    vecs.push_back('{0, 0, 6, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 1, 0, 0, 0, 0});   // TA falls with same latency
    vecs.push_back('{1, 0, 3, 0, 0, 0, 0});   // 3-cycle pulse from idle
    vecs.push_back('{0, 0, 10, 0, 0, 0, 0});
    vecs.push_back('{1, 1, 6, 0, 0, 0, 0});   // both lanes rise together
    vecs.push_back('{1, 1, 1, 1, 1, 0, 0});
    vecs.push_back('{1, 1, 3, 1, 1, 0, 0});
    vecs.push_back('{1, 0, 6, 1, 1, 0, 0});   // B falls 10 cycles after rise
    vecs.push_back('{1, 0, 1, 1, 0, 0, 0});
    vecs.push_back('{1, 0, 5, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 12, 0, 0, 0, 0});

    rst = 1'b1;
    bus.raw_a = 1'b0;
    bus.raw_b = 1'b0;
    m_reset();
    #1;
    chk("rst_TA", bus.TA, 1'b0);
    chk("rst_TB", bus.TB, 1'b0);
    chk("rst_fault_a", bus.fault_a, 1'b0);
    chk("rst_fault_b", bus.fault_b, 1'b0);
    repeat (3) cyc();
    rst = 1'b0;

    foreach (vecs[i]) begin
      bus.raw_a = vecs[i].ra;
      bus.raw_b = vecs[i].rb;
      repeat (vecs[i].n) cyc();
      chk($sformatf("vec%0d_TA", i), bus.TA, vecs[i].ta);
      chk($sformatf("vec%0d_TB", i), bus.TB, vecs[i].tb);
      chk($sformatf("vec%0d_fault_a", i), bus.fault_a, vecs[i].fa);
      chk($sformatf("vec%0d_fault_b", i), bus.fault_b, vecs[i].fb);
    end

    // Reset while TA is high drops it without a clock edge.
    bus.raw_a = 1'b1;
    repeat (8) cyc();
    chk("pre_rst_TA", bus.TA, 1'b1);
    rst = 1'b1;
    #1;
    chk("async_rst_TA", bus.TA, 1'b0);
    m_reset();
    cyc();
    rst = 1'b0;
    // Reset in QUAL_ON with cnt=2, raw_a held high throughout.
    repeat (4) cyc();
    chk("qual_on_TA", bus.TA, 1'b0);
    rst = 1'b1;
    #1;
    chk("qual_rst_TA", bus.TA, 1'b0);
    m_reset();
    cyc();
    rst = 1'b0;
    repeat (6) cyc();
    chk("post_rst_TA_6", bus.TA, 1'b0);
    cyc();
    chk("post_rst_TA_7", bus.TA, 1'b1);

    // Lane B held high long enough to trip stuck detection when enabled.
    bus.raw_a = 1'b0;
    repeat (12) cyc();
    bus.raw_b = 1'b1;
    repeat (7) cyc();
    chk("stuck_TB_on", bus.TB, 1'b1);
    repeat (19) cyc();
    chk("stuck_TB_19", bus.TB, 1'b1);
    chk("stuck_fb_19", bus.fault_b, 1'b0);
    cyc();
`ifdef SENSOR_STUCK_DETECT_EN
    chk("stuck_TB_20", bus.TB, 1'b0);
    chk("stuck_fb_20", bus.fault_b, 1'b1);
`else
    chk("stuck_TB_20", bus.TB, 1'b1);
    chk("stuck_fb_20", bus.fault_b, 1'b0);
`endif
    repeat (40) cyc();
`ifdef SENSOR_STUCK_DETECT_EN
    chk("stuck_fb_hold", bus.fault_b, 1'b1);
`else
    chk("stuck_TB_hold", bus.TB, 1'b1);
`endif
    bus.raw_b = 1'b0;
    repeat (5) cyc();
`ifdef SENSOR_STUCK_DETECT_EN
    chk("clear_fb_5", bus.fault_b, 1'b1);
`else
    chk("clear_TB_5", bus.TB, 1'b1);
`endif
    cyc();
    chk("clear_fb_6", bus.fault_b, 1'b0);
    chk("clear_TB_6", bus.TB, 1'b1 ^ `ifdef SENSOR_STUCK_DETECT_EN 1'b1 `else 1'b0 `endif);
    repeat (10) cyc();
    chk("idle_TB", bus.TB, 1'b0);

    // Randomized loops with occasional asynchronous reset.
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(11) == 0) bus.raw_a = ~bus.raw_a;
      if ($urandom_range(11) == 0) bus.raw_b = ~bus.raw_b;
      if ($urandom_range(599) == 0) begin
        rst = 1'b1;
        #1;
        m_reset();
        chk("rnd_rst_TA", bus.TA, 1'b0);
        chk("rnd_rst_TB", bus.TB, 1'b0);
        cyc();
        rst = 1'b0;
      end
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/traffic_sensor_conditioner.md
TRAFFIC_SENSOR_CONDITIONER -- requirements
Module: traffic_sensor_conditioner

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 4, giving the consecutive stable cycles needed to change a debounced output (legal range 1..2^CNT_W-1).
REQ-002 The block SHALL have parameter STUCK_CYCLES, default 1024, giving the continuous ACTIVE cycles after which a sensor is declared stuck (legal range DEB_CYCLES+1..2^CNT_W-1).
REQ-003 The block SHALL have parameter CNT_W, default 11, giving the width of each per-lane counter.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port raw_a, input, 1 bit: unsynchronised car-detect loop, lane A.
REQ-007 The block SHALL have port raw_b, input, 1 bit: unsynchronised car-detect loop, lane B.
REQ-008 The block SHALL have port TA, output, 1 bit: debounced traffic-present, lane A, driven directly to the light controller's TA.
REQ-009 The block SHALL have port TB, output, 1 bit: debounced traffic-present, lane B, driven directly to the light controller's TB.
REQ-010 The block SHALL have port fault_a, output, 1 bit: lane A stuck-sensor flag.
REQ-011 The block SHALL have port fault_b, output, 1 bit: lane B stuck-sensor flag.

Function
REQ-012 Each lane SHALL be an independent, identical channel; lane A maps raw_a->TA/fault_a and lane B maps raw_b->TB/fault_b.
REQ-013 Each raw input SHALL pass through a 2-flop synchroniser; the second flop output (s) is the only value the FSM uses.
REQ-014 Each channel SHALL have FSM states IDLE, QUAL_ON, ACTIVE, QUAL_OFF, FAULT and a CNT_W-bit counter cnt.
REQ-015 In IDLE, s=1 SHALL go to QUAL_ON with cnt=1; s=0 SHALL stay in IDLE.
REQ-016 In QUAL_ON, s=0 SHALL return to IDLE; s=1 with cnt==DEB_CYCLES SHALL go to ACTIVE with cnt=0; otherwise cnt SHALL increment.
REQ-017 In ACTIVE, s=0 SHALL go to QUAL_OFF with cnt=1; otherwise ACTIVE SHALL hold (stuck handling per REQ-025).
REQ-018 In QUAL_OFF, s=1 SHALL return to ACTIVE with cnt=0; s=0 with cnt==DEB_CYCLES SHALL go to IDLE; otherwise cnt SHALL increment.
REQ-019 T SHALL be registered and equal 1 exactly in ACTIVE and QUAL_OFF, so an off-glitch shorter than DEB_CYCLES never drops T.
REQ-020 Latency SHALL be DEB_CYCLES+2 rising edges from the first edge sampling raw high (raw held high) to T=1, and the same from the first edge sampling raw low to T=0.
REQ-021 A raw pulse or gap of at most DEB_CYCLES-1 cycles SHALL cause no change on T.
REQ-022 Counters SHALL never wrap; parameter legality guarantees the compare fires first.
REQ-023 Simultaneous events on both lanes SHALL be handled independently in the same cycle with no priority or interaction.

Reset
REQ-024 rst=1 SHALL at any time, including mid-qualification, force synchronisers to 0, both FSMs to IDLE, counters to 0, and TA, TB, fault_a, fault_b to 0 immediately; operation SHALL resume on the first clk edge after rst deasserts.

Configuration
REQ-025 With macro SENSOR_STUCK_DETECT_EN defined, cnt SHALL count ACTIVE cycles; on reaching STUCK_CYCLES the channel SHALL enter FAULT (T=0, fault=1), and FAULT SHALL exit to IDLE (fault=0) only after s=0 for DEB_CYCLES consecutive cycles, with any s=1 restarting that count.
REQ-026 Without SENSOR_STUCK_DETECT_EN, FAULT SHALL be unreachable, ACTIVE SHALL hold indefinitely while s=1, fault_a and fault_b SHALL be constant 0, and the ports SHALL remain present.

Verification
REQ-027 Reset, then raw_a=1 held -> TA=1 exactly 6 edges after first high sample (DEB_CYCLES=4); TB, fault_a and fault_b stay 0.
REQ-028 TA=1, then raw_a low for 3 cycles, then high -> TA stays 1 throughout; a 3-cycle high pulse from IDLE -> TA stays 0.
REQ-029 raw_a and raw_b rise on the same edge, raw_b falls 10 cycles later -> TA=1 and TB=1 on the same edge; TB=0 six edges after the first low sample, TA unaffected.
REQ-030 rst pulsed while lane A is in QUAL_ON (cnt=2) -> TA=0 immediately; after release with raw_a still high, TA=1 exactly 6 edges later.
REQ-031 SENSOR_STUCK_DETECT_EN defined, STUCK_CYCLES=20, raw_b held high -> TB=1, then TB=0 and fault_b=1 after 20 ACTIVE cycles; raw_b low for 4 cycles -> fault_b=0. Without the macro -> TB stays 1 and fault_b stays 0.
